// File: rtl/mtl_scan_compositor.sv
// LCD scan timing generator with SDRAM prefetch, frame-aligned base source selection,
// overlay compositing and sticky SDRAM underflow detection.
module mtl_scan_compositor #(
    parameter int H_LINE    = 1056,
    parameter int V_LINE    = 525,
    parameter int H_BLANK   = 46,
    parameter int H_FP      = 210,
    parameter int V_BLANK   = 23,
    parameter int V_FP      = 22,
    parameter int HS_W      = 1,
    parameter int VS_W      = 1,
    parameter int COLOR_W   = 8,
    parameter int FETCH_LAT = 2,
    parameter logic [3*COLOR_W-1:0] UF_COLOR = 24'hFF00FF
) (
    input  logic                 iCLK,
    input  logic                 iRST_n,
    input  logic [1:0]           iMode,
    input  logic [3*COLOR_W-1:0] iSolid,
    input  logic [3*COLOR_W-1:0] iREAD_DATA,
    input  logic                 iREAD_VALID,
    output logic                 oREAD_EN,
    output logic [10:0]          oX,
    output logic [9:0]           oY,
    output logic                 oPIX_ACTIVE,
    input  logic [3*COLOR_W-1:0] iOVL_RGB,
    input  logic                 iOVL_EN,
    input  logic                 iClrErr,
    output logic                 oUnderflow,
    output logic [1:0]           oModeActive,
    output logic                 oNewFrame,
    output logic                 oEndFrame,
    output logic                 oHD,
    output logic                 oVD,
    output logic [COLOR_W-1:0]   oLCD_R,
    output logic [COLOR_W-1:0]   oLCD_G,
    output logic [COLOR_W-1:0]   oLCD_B
);

    localparam int AW = H_LINE - H_BLANK - H_FP;
    localparam int AH = V_LINE - V_BLANK - V_FP;
    localparam int XW = $clog2(H_LINE);
    localparam int YW = $clog2(V_LINE);

    generate
        if (FETCH_LAT < 1 || FETCH_LAT > H_BLANK - 2) begin : g_bad_fetch_lat
            $error("mtl_scan_compositor: FETCH_LAT must lie in 1..H_BLANK-2");
        end
        if (AW <= 0 || AH <= 0) begin : g_bad_geometry
            $error("mtl_scan_compositor: active area must be non-empty");
        end
    endgenerate

    localparam logic [XW-1:0] X_LAST = XW'(H_LINE - 1);
    localparam logic [XW-1:0] X_ACT0 = XW'(H_BLANK);
    localparam logic [XW-1:0] X_ACT1 = XW'(H_BLANK + AW - 1);
    localparam logic [XW-1:0] X_REQ0 = XW'(H_BLANK - FETCH_LAT);
    localparam logic [XW-1:0] X_REQ1 = XW'(H_BLANK + AW - 1 - FETCH_LAT);
    localparam logic [XW-1:0] X_POS0 = XW'(H_BLANK - 2);
    localparam logic [XW-1:0] X_POS1 = XW'(H_BLANK + AW - 3);
    localparam logic [XW-1:0] X_END  = XW'(H_BLANK + AW);
    localparam logic [XW-1:0] X_HS   = XW'(HS_W);
    localparam logic [YW-1:0] Y_LAST = YW'(V_LINE - 1);
    localparam logic [YW-1:0] Y_ACT0 = YW'(V_BLANK);
    localparam logic [YW-1:0] Y_ACT1 = YW'(V_BLANK + AH - 1);
    localparam logic [YW-1:0] Y_VS   = YW'(VS_W);

    logic [XW-1:0]        x_cnt;
    logic [YW-1:0]        y_cnt;
    logic [1:0]           mode_q;
    logic                 y_act, pix_now, pos_win, uf_set, frame_start;
    logic [3*COLOR_W-1:0] base_rgb, comp_rgb;

    assign frame_start = (x_cnt == '0) && (y_cnt == '0);
    assign y_act       = (y_cnt >= Y_ACT0) && (y_cnt <= Y_ACT1);
    // Counter sits on the pixel itself: data/overlay are sampled now, pins show it next clock.
    assign pix_now     = y_act && (x_cnt >= X_ACT0) && (x_cnt <= X_ACT1);
    assign pos_win     = y_act && (x_cnt >= X_POS0) && (x_cnt <= X_POS1);
    assign oREAD_EN    = (mode_q == 2'd1) && y_act && (x_cnt >= X_REQ0) && (x_cnt <= X_REQ1);
    assign oModeActive = mode_q;
    assign uf_set      = pix_now && (mode_q == 2'd1) && !iREAD_VALID;

    always_comb begin
        base_rgb = '0;
        case (mode_q)
            2'd1:    base_rgb = iREAD_VALID ? iREAD_DATA : UF_COLOR;
            2'd2:    base_rgb = iSolid;
            default: base_rgb = '0;
        endcase
        comp_rgb = iOVL_EN ? iOVL_RGB : base_rgb;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            mode_q      <= 2'd0;
            oUnderflow  <= 1'b0;
            oPIX_ACTIVE <= 1'b0;
            oX          <= '0;
            oY          <= '0;
            oNewFrame   <= 1'b0;
            oEndFrame   <= 1'b0;
            oHD         <= 1'b1;
            oVD         <= 1'b1;
            oLCD_R      <= '0;
            oLCD_G      <= '0;
            oLCD_B      <= '0;
        end else begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
            if (frame_start) begin
                mode_q <= iMode;
            end
            oHD       <= !(x_cnt < X_HS);
            oVD       <= !(y_cnt < Y_VS);
            oNewFrame <= frame_start;
            oEndFrame <= (x_cnt == X_END) && (y_cnt == Y_ACT1);
            {oLCD_R, oLCD_G, oLCD_B} <= pix_now ? comp_rgb : '0;
            // A new underflow outranks a clear arriving in the same clock.
            oUnderflow  <= uf_set | (oUnderflow & ~iClrErr);
            oPIX_ACTIVE <= pos_win;
            if (pos_win) begin
                oX <= 11'(x_cnt - X_POS0);
                oY <= 10'(y_cnt - Y_ACT0);
            end
        end
    end

endmodule

// File: tb/tb_mtl_scan_compositor.sv
// Self-checking bench for mtl_scan_compositor on a small panel geometry; a cycle model
// predicts every output and a pixel scoreboard queue carries expected colours to the pins.
module tb_mtl_scan_compositor;

    localparam int H_LINE = 20, V_LINE = 10, H_BLANK = 5, H_FP = 3;
    localparam int V_BLANK = 2, V_FP = 2, HS_W = 2, VS_W = 2, FL = 3;
    localparam int AW = H_LINE - H_BLANK - H_FP;
    localparam int AH = V_LINE - V_BLANK - V_FP;
    localparam int FRAME = H_LINE * V_LINE;
    localparam logic [23:0] UF = 24'hFF00FF;

    logic        clk, rst_n;
    logic [1:0]  i_mode;
    logic [23:0] solid, rd_data, ovl_rgb;
    logic        rd_valid, ovl_en, clr;
    logic        read_en, pix_act, uf, nf, ef, hd, vd;
    logic [10:0] ox;
    logic [9:0]  oy;
    logic [1:0]  mode_act;
    logic [7:0]  lcd_r, lcd_g, lcd_b;

    mtl_scan_compositor #(
        .H_LINE(H_LINE), .V_LINE(V_LINE), .H_BLANK(H_BLANK), .H_FP(H_FP),
        .V_BLANK(V_BLANK), .V_FP(V_FP), .HS_W(HS_W), .VS_W(VS_W),
        .COLOR_W(8), .FETCH_LAT(FL), .UF_COLOR(UF)
    ) dut (
        .iCLK(clk), .iRST_n(rst_n), .iMode(i_mode), .iSolid(solid),
        .iREAD_DATA(rd_data), .iREAD_VALID(rd_valid), .oREAD_EN(read_en),
        .oX(ox), .oY(oy), .oPIX_ACTIVE(pix_act), .iOVL_RGB(ovl_rgb), .iOVL_EN(ovl_en),
        .iClrErr(clr), .oUnderflow(uf), .oModeActive(mode_act), .oNewFrame(nf),
        .oEndFrame(ef), .oHD(hd), .oVD(vd), .oLCD_R(lcd_r), .oLCD_G(lcd_g), .oLCD_B(lcd_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // model state: counter now (mx,my), counter of the pin cycle (px,py)
    int          mx, my, px, py;
    bit          pin_valid, muf;
    logic [1:0]  mmode;
    logic [23:0] exp_q[$];

    // stimulus knobs
    logic [1:0]  req_mode;
    logic [23:0] solid_k;
    bit          ovl_diag, rand_drop, rand_data, rand_clr;
    int          drop_c, drop_r, clr_x, clr_y;

    int cnt_req, cnt_nf, cnt_hd, cnt_vd;
    int n_checks, n_errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_act(input int x, input int y);
        return (x >= H_BLANK) && (x <= H_BLANK + AW - 1) && (y >= V_BLANK) && (y <= V_BLANK + AH - 1);
    endfunction

    function automatic logic [23:0] base_of(input logic [1:0] m, input logic [23:0] d,
                                            input bit v, input logic [23:0] s);
        case (m)
            2'd1:    return v ? d : UF;
            2'd2:    return s;
            default: return 24'h0;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hd"}, 32'(hd), 32'd1);
        chk({tag, "_vd"}, 32'(vd), 32'd1);
        chk({tag, "_nf"}, 32'(nf), 32'd0);
        chk({tag, "_ef"}, 32'(ef), 32'd0);
        chk({tag, "_rgb"}, 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
        chk({tag, "_read_en"}, 32'(read_en), 32'd0);
        chk({tag, "_pix_act"}, 32'(pix_act), 32'd0);
        chk({tag, "_x"}, 32'(ox), 32'd0);
        chk({tag, "_y"}, 32'(oy), 32'd0);
        chk({tag, "_mode"}, 32'(mode_act), 32'd0);
        chk({tag, "_uf"}, 32'(uf), 32'd0);
    endtask

    task automatic reset_model();
        mx = 0; my = 0; px = 0; py = 0;
        pin_valid = 0; muf = 0; mmode = 2'd0;
        exp_q.delete();
    endtask

    // driver + checker for one clock, called just after a falling edge
    task automatic step();
        logic [23:0] e, data, orgb;
        bit          valid, oen, exp_req, exp_pos;
        int          c, r;
        if (pin_valid) begin
            chk("hd", 32'(hd), (px < HS_W) ? 32'd0 : 32'd1);
            chk("vd", 32'(vd), (py < VS_W) ? 32'd0 : 32'd1);
            chk("new_frame", 32'(nf), 32'(px == 0 && py == 0));
            chk("end_frame", 32'(ef), 32'(px == H_BLANK + AW && py == V_BLANK + AH - 1));
            if (is_act(px, py)) begin
                if (exp_q.size() == 0) chk("pixel_queue_empty", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("pixel", 32'({lcd_r, lcd_g, lcd_b}), 32'(e));
                end
            end else begin
                chk("blank_rgb", 32'({lcd_r, lcd_g, lcd_b}), 32'd0);
            end
        end else begin
            check_reset_outputs("first_cycle");
        end
        chk("mode_active", 32'(mode_act), 32'(mmode));
        chk("underflow", 32'(uf), 32'(muf));
        exp_req = (mmode == 2'd1) && (my >= V_BLANK) && (my <= V_BLANK + AH - 1) &&
                  (mx >= H_BLANK - FL) && (mx <= H_BLANK + AW - 1 - FL);
        chk("read_en", 32'(read_en), 32'(exp_req));
        exp_pos = (my >= V_BLANK) && (my <= V_BLANK + AH - 1) &&
                  (mx >= H_BLANK - 1) && (mx <= H_BLANK + AW - 2);
        chk("pix_active", 32'(pix_act), 32'(exp_pos));
        if (exp_pos) begin
            chk("pos_x", 32'(ox), 32'(mx - (H_BLANK - 1)));
            chk("pos_y", 32'(oy), 32'(my - V_BLANK));
        end
        cnt_req += int'(read_en);
        cnt_nf  += int'(nf);
        cnt_hd  += int'(!hd);
        cnt_vd  += int'(!vd);

        i_mode = req_mode;
        solid  = solid_k;
        clr    = (mx == clr_x && my == clr_y) || (rand_clr && $urandom_range(0, 15) == 0);
        data   = 24'($urandom);
        valid  = ($urandom_range(0, 1) == 1);
        orgb   = 24'($urandom);
        oen    = ($urandom_range(0, 1) == 1);
        if (is_act(mx, my)) begin
            c = mx - H_BLANK;
            r = my - V_BLANK;
            data  = rand_data ? 24'($urandom) : {8'(r), 8'(c), 8'h5A};
            valid = !((c == drop_c && r == drop_r) || (rand_drop && $urandom_range(0, 7) == 0));
            oen   = ovl_diag && (c == r);
            e     = oen ? orgb : base_of(mmode, data, valid, solid_k);
            exp_q.push_back(e);
            if (mmode == 2'd1 && !valid) muf = 1'b1;
            else if (clr) muf = 1'b0;
        end else if (clr) begin
            muf = 1'b0;
        end
        rd_data  = data;
        rd_valid = valid;
        ovl_rgb  = orgb;
        ovl_en   = oen;

        if (mx == 0 && my == 0) mmode = req_mode;
        px = mx; py = my; pin_valid = 1;
        if (mx == H_LINE - 1) begin
            mx = 0;
            my = (my == V_LINE - 1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            step();
        end
    endtask

    // run until the next clock will hold counter state (x,y)
    task automatic to_pos(input int x, input int y);
        int guard = 0;
        do begin
            @(negedge clk);
            step();
            guard++;
        end while (!(mx == x && my == y) && guard < FRAME + 2);
        if (!(mx == x && my == y)) chk("to_pos_timeout", 32'd1, 32'd0);
    endtask

    task automatic clear_counts();
        cnt_req = 0; cnt_nf = 0; cnt_hd = 0; cnt_vd = 0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        req_mode = 2'd0; solid_k = 24'h0;
        ovl_diag = 0; rand_drop = 0; rand_data = 0; rand_clr = 0;
        drop_c = -1; drop_r = -1; clr_x = -1; clr_y = -1;
        clear_counts();
        rst_n = 1'b0; i_mode = 2'd0; solid = '0; rd_data = '0; rd_valid = 1'b0;
        ovl_rgb = '0; ovl_en = 1'b0; clr = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // pattern mode: black base, sync widths, frame period, no requests
        to_pos(0, 0);
        clear_counts();
        cycles(2 * FRAME);
        chk("m0_new_frames", 32'(cnt_nf), 32'd2);
        chk("m0_hd_low", 32'(cnt_hd), 32'(2 * HS_W * V_LINE));
        chk("m0_vd_low", 32'(cnt_vd), 32'(2 * VS_W * H_LINE));
        chk("m0_requests", 32'(cnt_req), 32'd0);

        // SDRAM mode with patterned data
        req_mode = 2'd1;
        to_pos(0, 0);
        cycles(1);
        clear_counts();
        cycles(FRAME);
        chk("m1_requests", 32'(cnt_req), 32'(AW * AH));

        // single underflow at (10,5), then clear, then underflow racing a clear
        to_pos(0, 0);
        drop_c = 10; drop_r = 5;
        cycles(FRAME);
        drop_c = -1; drop_r = -1;
        chk("uf_sticky", 32'(uf), 32'd1);
        clr_x = 0; clr_y = 1;
        cycles(FRAME);
        chk("uf_cleared", 32'(uf), 32'd0);
        drop_c = 3; drop_r = 2; clr_x = H_BLANK + 3; clr_y = V_BLANK + 2;
        cycles(FRAME);
        drop_c = -1; drop_r = -1; clr_x = -1; clr_y = -1;
        chk("uf_set_wins", 32'(uf), 32'd1);

        // solid to SDRAM switch requested mid-frame
        req_mode = 2'd2; solid_k = 24'h123456;
        to_pos(0, 0);
        to_pos(0, V_BLANK + 2);
        req_mode = 2'd1;
        clear_counts();
        to_pos(0, 0);
        chk("switch_no_requests", 32'(cnt_req), 32'd0);
        cycles(1);
        clear_counts();
        cycles(FRAME);
        chk("switch_requests", 32'(cnt_req), 32'(AW * AH));

        // diagonal overlay over random SDRAM data with random drops and clears
        ovl_diag = 1; rand_data = 1; rand_drop = 1; rand_clr = 1;
        cycles(2 * FRAME);
        req_mode = 2'd2; solid_k = 24'($urandom);
        cycles(2 * FRAME);
        req_mode = 2'd3;
        cycles(2 * FRAME);
        rand_drop = 0; rand_clr = 0;

        // asynchronous reset in the middle of an active line
        req_mode = 2'd1;
        to_pos(0, 0);
        to_pos(9, 4);
        @(negedge clk);
        step();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        step();
        clear_counts();
        cycles(FRAME + 5);
        chk("post_reset_new_frames", 32'(cnt_nf), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
